// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory burst controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  localparam int unsigned RD_FIFO_DEPTH = 4;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Command, write-stream, read-stream and memory-request signals of the burst controller.
interface mem_burst_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [WIDTH-1:0]      wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [WIDTH-1:0]      rd_data;
  logic                  mem_valid;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  mem_ready;
  logic [WIDTH-1:0]      mem_rdata;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output mem_valid, mem_wr, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  mem_valid, mem_wr, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_rd_fifo.sv
// Small synchronous FIFO buffering read returns; overflow is prevented upstream by credits.
module mem_rd_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (push_i) wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    if (pop_i)  rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push_i) mem_q[wptr_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = (count_q == '0) ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller: turns write/read streams into per-word memory requests,
// with credit-limited read issue into a small return FIFO.
module mem_burst_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_burst_ctrl_if.slave   bus,
  output logic              busy,
  output logic              done
);
  localparam int unsigned CNT_W = LEN_WIDTH + 1;
  localparam int unsigned CRW   = $clog2(RD_FIFO_DEPTH + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, next_addr;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CNT_W-1:0]      issued_q, issued_d;
  logic [CNT_W-1:0]      popped_q, popped_d;
  logic [CRW-1:0]        inflight_q, inflight_d;
  logic [1:0]            rpend_q, rpend_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                  done_q, done_d;

  logic [CRW-1:0]   fifo_count;
  logic [WIDTH-1:0] fifo_head;
  logic [CRW:0]     occupancy;
  logic             wr_hs, rd_issue, push, pop;

  assign next_addr = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign wr_hs     = (state_q == WRITE) && bus.wr_valid;
  assign rd_issue  = (state_q == READ) && (issued_q <= {1'b0, len_q})
                     && (occupancy < (CRW + 1)'(RD_FIFO_DEPTH));
  // rpend_q[1] lines up with the mem_ready of a read issued two cycles earlier.
  assign push      = bus.mem_ready && rpend_q[1];
  assign pop       = (fifo_count != '0) && bus.rd_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    popped_d    = popped_q;
    inflight_d  = inflight_q + CRW'(rd_issue) - CRW'(push);
    rpend_d     = {rpend_q[0], rd_issue};
    mem_valid_d = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d   = bus.cmd_addr;
          len_d    = bus.cmd_len;
          issued_d = '0;
          popped_d = '0;
          state_d  = bus.cmd_wr ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_hs) begin
          mem_valid_d = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = bus.wr_data;
          addr_d      = next_addr;
          issued_d    = issued_q + CNT_W'(1);
          if (issued_q == {1'b0, len_q}) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (rd_issue) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = addr_q;
          addr_d      = next_addr;
          issued_d    = issued_q + CNT_W'(1);
        end
        if (pop) begin
          popped_d = popped_q + CNT_W'(1);
          if (popped_q == {1'b0, len_q}) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      inflight_q  <= '0;
      rpend_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      popped_q    <= popped_d;
      inflight_q  <= inflight_d;
      rpend_q     <= rpend_d;
      mem_valid_q <= mem_valid_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
    end
  end

  mem_rd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RD_FIFO_DEPTH),
    .CNT_W (CRW)
  ) u_rd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (bus.mem_rdata),
    .pop_i   (pop),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wr_ready  = (state_q == WRITE);
  assign bus.rd_valid  = (fifo_count != '0);
  assign bus.rd_data   = fifo_head;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule
